// File: rtl/two_bit_sequencer.sv
// Microprogram sequencer for the two-bit ALU.
// Holds a small program of (opcode, B-operand) words, steps through them and
// feeds the ALU result back as operand A through an accumulator. Each
// instruction takes one ISSUE cycle and one CAPTURE cycle. The ALU operand and
// opcode ports are registered and hold their last values outside a run.
module two_bit_sequencer #(
    parameter int DEPTH         = 8,
    parameter int AW            = 3,
    parameter bit HALT_ON_ERROR = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic [1:0]    init_a,
    output logic [1:0]    alu_a,
    output logic [1:0]    alu_b,
    output logic [1:0]    alu_i,
    input  logic [1:0]    alu_f,
    input  logic          alu_error,
    output logic          busy,
    output logic          done,
    output logic [1:0]    result,
    output logic          err,
    output logic [AW-1:0] err_pc
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PC_ONE  = AW'(1);

    // Program memory; deliberately not reset so a loaded program survives rst.
    logic [3:0] mem [DEPTH];

    state_t        state_reg,  state_next;
    logic [AW-1:0] pc_reg,     pc_next;
    logic [1:0]    acc_reg,    acc_next;
    logic [AW:0]   cnt_reg,    cnt_next;
    logic          err_reg,    err_next;
    logic [AW-1:0] err_pc_reg, err_pc_next;

    logic          busy_reg;
    logic          done_reg;
    logic [1:0]    result_reg;
    logic [1:0]    alu_a_reg;
    logic [1:0]    alu_b_reg;
    logic [1:0]    alu_i_reg;

    logic [AW:0]   len_clamped;
    logic [3:0]    fetch_word;
    logic          write_ok;
    logic          halt;

    assign write_ok    = (state_reg == IDLE) && wr_en;
    assign len_clamped = (len > DEPTH_N) ? DEPTH_N : len;

    // Word for the instruction about to be issued. A write landing on the same
    // edge as an accepted start is forwarded so the run sees the new word.
    assign fetch_word = (write_ok && (wr_addr == pc_next)) ? wr_data : mem[pc_next];

    // Program load port, only open while idle.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next-state and datapath update logic for the sequencer.
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        acc_next    = acc_reg;
        cnt_next    = cnt_reg;
        err_next    = err_reg;
        err_pc_next = err_pc_reg;
        halt        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    acc_next    = init_a;
                    pc_next     = '0;
                    cnt_next    = len_clamped;
                    err_next    = 1'b0;
                    err_pc_next = '0;
                    state_next  = (len_clamped == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                if (!alu_error) begin
                    acc_next = alu_f;
                end else begin
                    if (!err_reg) begin
                        err_next    = 1'b1;
                        err_pc_next = pc_reg;
                    end
                    if (HALT_ON_ERROR) begin
                        halt = 1'b1;
                    end else begin
                        acc_next = alu_f;
                    end
                end
                if (halt || ({1'b0, pc_reg} == (cnt_reg - CNT_ONE))) begin
                    state_next = DONE;
                end else begin
                    pc_next    = pc_reg + PC_ONE;
                    state_next = ISSUE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; ALU ports load on entry to ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            err_reg    <= 1'b0;
            err_pc_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_i_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            acc_reg    <= acc_next;
            cnt_reg    <= cnt_next;
            err_reg    <= err_next;
            err_pc_reg <= err_pc_next;
            busy_reg   <= (state_next == ISSUE) || (state_next == CAPTURE);
            done_reg   <= (state_next == DONE);
            if (state_next == DONE) begin
                result_reg <= acc_next;
            end
            if (state_next == ISSUE) begin
                alu_a_reg <= acc_next;
                alu_i_reg <= fetch_word[3:2];
                alu_b_reg <= fetch_word[1:0];
            end
        end
    end

    assign alu_a  = alu_a_reg;
    assign alu_b  = alu_b_reg;
    assign alu_i  = alu_i_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign err    = err_reg;
    assign err_pc = err_pc_reg;

endmodule

// File: tb/tb_two_bit_sequencer.sv
// Bench for two_bit_sequencer: one instance halting on error, one continuing,
// driven with the same program and stimulus and checked against a
// behavioural model of the program run.
module tb_two_bit_sequencer;

    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_data;
    logic          start;
    logic [AW:0]   len;
    logic [1:0]    init_a;

    logic [1:0]    a_h, b_h, i_h, f_h, result_h;
    logic          ae_h, busy_h, done_h, err_h;
    logic [AW-1:0] errpc_h;
    logic [1:0]    a_c, b_c, i_c, f_c, result_c;
    logic          ae_c, busy_c, done_c, err_c;
    logic [AW-1:0] errpc_c;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] ref_mem [8];

    two_bit_sequencer #(.DEPTH(8), .AW(AW), .HALT_ON_ERROR(1'b1)) dut_h (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .init_a(init_a),
        .alu_a(a_h), .alu_b(b_h), .alu_i(i_h), .alu_f(f_h), .alu_error(ae_h),
        .busy(busy_h), .done(done_h), .result(result_h), .err(err_h), .err_pc(errpc_h)
    );

    two_bit_sequencer #(.DEPTH(8), .AW(AW), .HALT_ON_ERROR(1'b0)) dut_c (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .init_a(init_a),
        .alu_a(a_c), .alu_b(b_c), .alu_i(i_c), .alu_f(f_c), .alu_error(ae_c),
        .busy(busy_c), .done(done_c), .result(result_c), .err(err_c), .err_pc(errpc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: 00 add (error on carry), 01 subtract (error on borrow), 10 xor, 11 and.
    function automatic logic [2:0] alu_fn(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        case (op)
            2'b00:   s = {1'b0, a} + {1'b0, b};
            2'b01:   s = {(a < b), 2'(a - b)};
            2'b10:   s = {1'b0, a ^ b};
            default: s = {1'b0, a & b};
        endcase
        return s;
    endfunction

    assign {ae_h, f_h} = alu_fn(i_h, a_h, b_h);
    assign {ae_c, f_c} = alu_fn(i_c, a_c, b_c);

    // Reference: run the program with integer arithmetic.
    function automatic void model(input int ia, input int ln, input bit halt_mode,
                                  output int cyc, output int res, output int e, output int epc);
        int n, acc, op, b, f, er, s;
        n = (ln > 8) ? 8 : ln;
        acc = ia; e = 0; epc = 0; cyc = 1;
        for (int k = 0; k < n; k++) begin
            op = int'(ref_mem[k][3:2]);
            b  = int'(ref_mem[k][1:0]);
            case (op)
                0: begin s = acc + b; f = s % 4; er = (s > 3) ? 1 : 0; end
                1: begin s = acc - b; f = (s + 4) % 4; er = (s < 0) ? 1 : 0; end
                2: begin f = acc ^ b; er = 0; end
                default: begin f = acc & b; er = 0; end
            endcase
            cyc = 2 * (k + 1) + 1;
            if (er != 0) begin
                if (e == 0) begin e = 1; epc = k; end
                if (halt_mode) break;
            end
            acc = f;
        end
        res = acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [3:0] data);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
        ref_mem[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_random();
        for (int k = 0; k < 8; k++) load(k, 4'($urandom_range(0, 15)));
    endtask

    // Start a run at the next edge, watch both instances cycle by cycle and
    // compare done timing, pulse count, busy, result and error flags.
    // poke: pulse start and wr_en while busy. short_win: return in the first
    // IDLE cycle after done so the next run can start back to back.
    task automatic run_check(input string name, input logic [1:0] ia, input logic [AW:0] ln,
                             input bit poke, input bit short_win);
        int cyc_h, res_h, e_h, epc_h, cyc_c, res_c, e_c, epc_c;
        int got_h, got_c, pul_h, pul_c, limit;
        logic [1:0] gres_h, gres_c;
        logic gerr_h, gerr_c;
        logic [AW-1:0] gpc_h, gpc_c;
        model(int'(ia), int'(ln), 1'b1, cyc_h, res_h, e_h, epc_h);
        model(int'(ia), int'(ln), 1'b0, cyc_c, res_c, e_c, epc_c);
        init_a = ia; len = ln; start = 1'b1;
        tick();
        start = 1'b0;
        got_h = 0; got_c = 0; pul_h = 0; pul_c = 0;
        gres_h = '0; gres_c = '0; gerr_h = 1'b0; gerr_c = 1'b0; gpc_h = '0; gpc_c = '0;
        limit = ((cyc_h > cyc_c) ? cyc_h : cyc_c) + (short_win ? 0 : 4);
        for (int c = 1; c <= limit; c++) begin
            n_cmp += 2;
            if (busy_h !== (c < cyc_h)) begin
                n_bad++;
                $display("FAIL %s busy_halt cycle %0d: got %b expected %b", name, c, busy_h, (c < cyc_h));
            end
            if (busy_c !== (c < cyc_c)) begin
                n_bad++;
                $display("FAIL %s busy_cont cycle %0d: got %b expected %b", name, c, busy_c, (c < cyc_c));
            end
            if (done_h === 1'b1) begin
                pul_h++;
                if (got_h == 0) begin got_h = c; gres_h = result_h; gerr_h = err_h; gpc_h = errpc_h; end
            end
            if (done_c === 1'b1) begin
                pul_c++;
                if (got_c == 0) begin got_c = c; gres_c = result_c; gerr_c = err_c; gpc_c = errpc_c; end
            end
            if (poke && c == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = ~ref_mem[0];
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            tick();
        end
        n_cmp += 12;
        if (got_h != cyc_h) begin n_bad++; $display("FAIL %s done_cycle_halt: got %0d expected %0d", name, got_h, cyc_h); end
        if (got_c != cyc_c) begin n_bad++; $display("FAIL %s done_cycle_cont: got %0d expected %0d", name, got_c, cyc_c); end
        if (pul_h != 1) begin n_bad++; $display("FAIL %s done_pulses_halt: got %0d expected 1", name, pul_h); end
        if (pul_c != 1) begin n_bad++; $display("FAIL %s done_pulses_cont: got %0d expected 1", name, pul_c); end
        if (gres_h !== 2'(res_h)) begin n_bad++; $display("FAIL %s result_halt: got %0d expected %0d", name, gres_h, res_h); end
        if (gres_c !== 2'(res_c)) begin n_bad++; $display("FAIL %s result_cont: got %0d expected %0d", name, gres_c, res_c); end
        if (gerr_h !== 1'(e_h)) begin n_bad++; $display("FAIL %s err_halt: got %b expected %0d", name, gerr_h, e_h); end
        if (gerr_c !== 1'(e_c)) begin n_bad++; $display("FAIL %s err_cont: got %b expected %0d", name, gerr_c, e_c); end
        if (gpc_h !== AW'(epc_h)) begin n_bad++; $display("FAIL %s err_pc_halt: got %0d expected %0d", name, gpc_h, epc_h); end
        if (gpc_c !== AW'(epc_c)) begin n_bad++; $display("FAIL %s err_pc_cont: got %0d expected %0d", name, gpc_c, epc_c); end
        if (result_h !== 2'(res_h)) begin n_bad++; $display("FAIL %s result_hold_halt: got %0d expected %0d", name, result_h, res_h); end
        if (result_c !== 2'(res_c)) begin n_bad++; $display("FAIL %s result_hold_cont: got %0d expected %0d", name, result_c, res_c); end
        $display("run %s init=%0d len=%0d: halt done@%0d res=%0d err=%b pc=%0d | cont done@%0d res=%0d err=%b pc=%0d",
                 name, ia, ln, got_h, gres_h, gerr_h, gpc_h, got_c, gres_c, gerr_c, gpc_c);
    endtask

    task automatic check_zero(input string name);
        n_cmp += 2;
        if ({busy_h, done_h, result_h, err_h, errpc_h, a_h, b_h, i_h} !== '0) begin
            n_bad++;
            $display("FAIL %s halt_outputs: got busy=%b done=%b result=%0d err=%b err_pc=%0d a=%0d b=%0d i=%0d expected all 0",
                     name, busy_h, done_h, result_h, err_h, errpc_h, a_h, b_h, i_h);
        end
        if ({busy_c, done_c, result_c, err_c, errpc_c, a_c, b_c, i_c} !== '0) begin
            n_bad++;
            $display("FAIL %s cont_outputs: got busy=%b done=%b result=%0d err=%b err_pc=%0d a=%0d b=%0d i=%0d expected all 0",
                     name, busy_c, done_c, result_c, err_c, errpc_c, a_c, b_c, i_c);
        end
        $display("check %s: reset output state examined", name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        load_random();
        load(0, 4'b0001);
        load(1, 4'b0001);
        load(2, 4'b0100);
        run_check("basic", 2'b00, 4'd3, 1'b0, 1'b0);
    endtask

    task automatic test_error();
        load(0, 4'b0011);
        load(1, 4'b0011);
        run_check("error", 2'b01, 4'd2, 1'b0, 1'b0);
    endtask

    task automatic test_boundaries();
        run_check("len_zero", 2'($urandom_range(0, 3)), 4'd0, 1'b0, 1'b0);
        load_random();
        run_check("len_clamp", 2'($urandom_range(0, 3)), 4'd15, 1'b0, 1'b0);
    endtask

    task automatic test_busy_ignore();
        load_random();
        run_check("busy_poke", 2'($urandom_range(0, 3)), 4'd5, 1'b1, 1'b0);
        run_check("after_poke", 2'($urandom_range(0, 3)), 4'd8, 1'b0, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int pulses;
        // Error-free opcodes so no instance finishes early before the reset.
        for (int k = 0; k < 8; k++) load(k, {1'b1, 3'($urandom_range(0, 7))});
        load(0, 4'b1011);
        init_a = 2'b10; len = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("reset_midrun");
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_h === 1'b1 || done_c === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL reset_midrun done_after_reset: got %0d pulses expected 0", pulses);
        end
        run_check("rerun", 2'b11, 4'd4, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            load_random();
            run_check("random", 2'($urandom_range(0, 3)), (AW+1)'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) load(k, {1'b1, 3'($urandom_range(0, 7))});
        run_check("b2b_first", 2'($urandom_range(0, 3)), 4'd3, 1'b0, 1'b1);
        run_check("b2b_second", 2'($urandom_range(0, 3)), 4'd6, 1'b0, 1'b1);
        run_check("b2b_third", 2'($urandom_range(0, 3)), 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; len = '0; init_a = '0;
        for (int k = 0; k < 8; k++) ref_mem[k] = '0;
        test_reset();
        test_basic();
        test_error();
        test_boundaries();
        test_busy_ignore();
        test_reset_midrun();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
